// File: rtl/axi_mm2s_mem_slave.sv
// AXI4 read-only memory slave that serves MM2S bursts out of an internal
// word memory. The memory is filled through a backdoor write port. One burst
// is outstanding at a time, with a one-cycle AR-to-first-beat latency.
module axi_mm2s_mem_slave #(
   parameter int          MEM_DEPTH = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        axi_aclk,
   input  logic        axi_reset,
   input  logic [31:0] m_axi_mm2s_araddr,
   input  logic [7:0]  m_axi_mm2s_arlen,
   input  logic [2:0]  m_axi_mm2s_arsize,
   input  logic [1:0]  m_axi_mm2s_arburst,
   input  logic [2:0]  m_axi_mm2s_arprot,
   input  logic [3:0]  m_axi_mm2s_arcache,
   input  logic        m_axi_mm2s_arvalid,
   output logic        m_axi_mm2s_arready,
   output logic [31:0] m_axi_mm2s_rdata,
   output logic [1:0]  m_axi_mm2s_rresp,
   output logic        m_axi_mm2s_rlast,
   output logic        m_axi_mm2s_rvalid,
   input  logic        m_axi_mm2s_rready,
   input  logic        mem_we,
   input  logic [15:0] mem_waddr,
   input  logic [31:0] mem_wdata,
   output logic        burst_done
);

   localparam int          AW        = $clog2(MEM_DEPTH);
   localparam logic [31:0] MEM_LIMIT = 32'(MEM_DEPTH);
   localparam logic [16:0] WR_LIMIT  = 17'(MEM_DEPTH);

   typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

   state_t      state_q;
   state_t      state_d;
   logic [31:0] mem [MEM_DEPTH];

   logic [31:0] beat_addr_q;
   logic [7:0]  beat_cnt_q;
   logic [7:0]  len_q;
   logic        fixed_q;
   logic        bad_burst_q;

   logic        ar_fire;
   logic        r_fire;
   logic        last_fire;
   logic [31:0] next_addr;
   logic [7:0]  next_cnt;

   logic [31:0] fetch_addr;
   logic [31:0] fetch_offset;
   logic        fetch_bad_burst;
   logic        fetch_oob;
   logic        fetch_err;
   logic [31:0] fetch_data;
   logic        unused_bits;

   assign m_axi_mm2s_arready = (state_q == IDLE) && !axi_reset;
   assign ar_fire            = m_axi_mm2s_arvalid && m_axi_mm2s_arready;
   assign r_fire             = m_axi_mm2s_rvalid && m_axi_mm2s_rready;
   assign last_fire          = r_fire && m_axi_mm2s_rlast;
   assign next_addr          = fixed_q ? beat_addr_q : beat_addr_q + 32'd4;
   assign next_cnt           = beat_cnt_q + 8'd1;
   assign unused_bits        = ^{m_axi_mm2s_arprot, m_axi_mm2s_arcache, fetch_offset[1:0]};

   // State register; reset parks the FSM in IDLE
   always_ff @(posedge axi_aclk) begin
      if (axi_reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: an AR accept starts a burst, the last R handshake ends it
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (ar_fire)   state_d = BURST;
         BURST:   if (last_fire) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Work out which word the next registered beat comes from and whether it errors
   always_comb begin
      fetch_addr      = ar_fire ? m_axi_mm2s_araddr : next_addr;
      fetch_bad_burst = ar_fire ? ((m_axi_mm2s_arsize != 3'b010) || m_axi_mm2s_arburst[1])
                                : bad_burst_q;
      fetch_offset    = fetch_addr - BASE_ADDR;
      fetch_oob       = (fetch_addr < BASE_ADDR) || ({2'b00, fetch_offset[31:2]} >= MEM_LIMIT);
      fetch_err       = fetch_bad_burst || fetch_oob;
      fetch_data      = fetch_err ? 32'd0 : mem[fetch_offset[AW+1:2]];
   end

   // Backdoor preload port; out-of-range word addresses are dropped, never cleared by reset
   always_ff @(posedge axi_aclk) begin
      if (mem_we && ({1'b0, mem_waddr} < WR_LIMIT)) begin
         mem[mem_waddr[AW-1:0]] <= mem_wdata;
      end
   end

   // R channel: register each beat on AR accept or on a non-final handshake
   always_ff @(posedge axi_aclk) begin
      if (axi_reset) begin
         m_axi_mm2s_rvalid <= 1'b0;
         m_axi_mm2s_rlast  <= 1'b0;
         m_axi_mm2s_rresp  <= 2'b00;
         m_axi_mm2s_rdata  <= 32'd0;
         burst_done        <= 1'b0;
         beat_addr_q       <= 32'd0;
         beat_cnt_q        <= 8'd0;
         len_q             <= 8'd0;
         fixed_q           <= 1'b0;
         bad_burst_q       <= 1'b0;
      end else begin
         burst_done <= last_fire;
         if (ar_fire) begin
            beat_addr_q       <= m_axi_mm2s_araddr;
            beat_cnt_q        <= 8'd0;
            len_q             <= m_axi_mm2s_arlen;
            fixed_q           <= (m_axi_mm2s_arburst == 2'b00);
            bad_burst_q       <= fetch_bad_burst;
            m_axi_mm2s_rvalid <= 1'b1;
            m_axi_mm2s_rlast  <= (m_axi_mm2s_arlen == 8'd0);
            m_axi_mm2s_rresp  <= fetch_err ? 2'b10 : 2'b00;
            m_axi_mm2s_rdata  <= fetch_data;
         end else if (r_fire) begin
            if (m_axi_mm2s_rlast) begin
               m_axi_mm2s_rvalid <= 1'b0;
               m_axi_mm2s_rlast  <= 1'b0;
               m_axi_mm2s_rresp  <= 2'b00;
               m_axi_mm2s_rdata  <= 32'd0;
            end else begin
               beat_addr_q      <= next_addr;
               beat_cnt_q       <= next_cnt;
               m_axi_mm2s_rlast <= (next_cnt == len_q);
               m_axi_mm2s_rresp <= fetch_err ? 2'b10 : 2'b00;
               m_axi_mm2s_rdata <= fetch_data;
            end
         end
      end
   end

endmodule

// File: doc/axi_mm2s_mem_slave.md
AXI_MM2S_MEM_SLAVE -- requirements
Module: axi_mm2s_mem_slave

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 1024: number of 32-bit words in the internal memory (power of two, 16..65536).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address of memory word 0.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 Port axi_aclk, input, 1: the single clock; all logic samples on its rising edge.
REQ-005 Port axi_reset, input, 1: synchronous active-high reset.
REQ-006 Ports m_axi_mm2s_araddr, input, 32, and m_axi_mm2s_arlen, input, 8: burst start byte address and beats-1.
REQ-007 Ports m_axi_mm2s_arsize, input, 3, and m_axi_mm2s_arburst, input, 2: beat size and burst type.
REQ-008 Ports m_axi_mm2s_arprot, input, 3, and m_axi_mm2s_arcache, input, 4: accepted and ignored.
REQ-009 Ports m_axi_mm2s_arvalid, input, 1, and m_axi_mm2s_arready, output, 1: AR handshake.
REQ-010 Ports m_axi_mm2s_rdata, output, 32, and m_axi_mm2s_rresp, output, 2: beat data and response.
REQ-011 Ports m_axi_mm2s_rlast, output, 1, m_axi_mm2s_rvalid, output, 1, and m_axi_mm2s_rready, input, 1: R channel.
REQ-012 Ports mem_we, input, 1, mem_waddr, input, 16, and mem_wdata, input, 32: backdoor word-write port for preloading memory.
REQ-013 Port burst_done, output, 1: pulses high for one cycle after the last R beat of every burst is accepted.

Function
REQ-014 SHALL implement FSM states IDLE and BURST.
- IDLE: arready=1. AR handshake (arvalid&arready) moves to BURST.
- BURST: arready=0. Only one burst is outstanding at a time.
REQ-015 On AR accept in cycle N, the block SHALL latch addr/len/size/burst and present beat 0 with rvalid=1 in cycle N+1; latency is 1 cycle.
REQ-016 A beat SHALL complete only on rvalid&rready. rdata, rresp and rlast SHALL hold stable while rvalid=1 and rready=0.
REQ-017 Beat address calculation:
- Word index = ((beat_addr - BASE_ADDR) >> 2); araddr[1:0] are ignored.
- INCR (2'b01): word index +1 per beat.
- FIXED (2'b00): the same word on every beat.
REQ-018 The next beat's data SHALL be registered on the handshake cycle and be valid the following cycle, with no bubble when rready stays high.
REQ-019 rlast SHALL be 1 exactly on beat arlen (arlen=0 gives one beat with rlast=1).
REQ-020 On the last handshake, the block SHALL drive rvalid=0, rlast=0 and burst_done=1 the next cycle, return to IDLE, and drive arready=1 that same next cycle.
REQ-021 rresp=2'b10 (SLVERR) with rdata=0 SHALL be driven for every beat of a burst whose arsize!=3'b010 or arburst=2'b10/2'b11; the beat count is still honoured.
REQ-022 A beat whose word index is >= MEM_DEPTH or below BASE_ADDR SHALL return rresp=SLVERR and rdata=0; other beats of the same burst return OKAY.
REQ-023 Otherwise rresp SHALL be 2'b00.
REQ-024 INCR address arithmetic SHALL be 32-bit modulo 2^32; no 4 KB boundary check is performed.
REQ-025 Backdoor writes SHALL take effect at the clock edge regardless of FSM state.
- mem_waddr values >= MEM_DEPTH are dropped.
- A write and a beat fetch of the same word in the same cycle SHALL return the old data (read-before-write).
REQ-026 arvalid asserted while in BURST SHALL be ignored and not lost; it is accepted on return to IDLE.

Reset
REQ-027 While axi_reset=1, the block SHALL drive arready=0, rvalid=0, rlast=0, rresp=0, rdata=0 and burst_done=0, and the FSM SHALL be in IDLE.
REQ-028 The first cycle after reset deasserts SHALL drive arready=1.
REQ-029 Reset asserted mid-burst SHALL abort the burst immediately with no further R beats and no burst_done.
REQ-030 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-031 Preload words 0..3 = 32'hA0..A3, then issue AR addr=0x0, len=3, INCR, size=2 with rready=1 -> 4 consecutive beats A0..A3 starting 1 cycle after AR, rlast on beat 3, burst_done next cycle.
REQ-032 Repeat the REQ-031 burst with rready toggling 1/0 each cycle -> data and rlast are held while stalled, sequence is unchanged, and there are no extra beats.
REQ-033 FIXED burst addr=0x8, len=2 -> three beats all 32'hA2, OKAY.
REQ-034 AR addr=(MEM_DEPTH-2)*4, len=3, INCR -> beats 0-1 OKAY, beats 2-3 SLVERR with rdata=0.
REQ-035 AR with arsize=3'b001 len=1, then WRAP len=1 -> 2 SLVERR beats each; assert reset during beat 1 of a 4-beat burst -> rvalid=0 next cycle and arready=1 after release.
REQ-036 Hold arvalid high through a 4-beat burst -> second AR accepted in the cycle after burst_done's cycle N, first beat in N+1; same-cycle backdoor write to the beat word returns the old value.
